// File: rtl/host_stim_adapter.sv
// ============================================================================
// Module      : host_stim_adapter
// Description : Controller-side stimulus for the robot FPGA bench: a mode-0
//               32-bit SPI master, a push-button pulse generator and
//               NUM_ECHO sonar echo responders. All timing in clk cycles.
//               Optional build macro ADAPTER_CHECK_EN enables reply checking
//               (sticky spi_err plus saturating spi_err_cnt output).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_stim_adapter #(
   parameter int CLK_DIV    = 2,   // SCLK half-period in clk cycles, >= 1
   parameter int CS_GAP     = 4,   // idle cycles with CS high between frames, >= 1
   parameter int NUM_ECHO   = 6,
   parameter int ECHO_DELAY = 50,  // trigger fall to echo rise, >= 1
   parameter int PULSE_W    = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   // SPI sequencer side
   input  logic                spi_start,
   input  logic [31:0]         spi_tx,
   input  logic [31:0]         spi_exp,
   input  logic                spi_exp_valid,
   output logic                spi_busy,
   output logic                spi_done,
   output logic [31:0]         spi_rx,
   output logic                spi_err,
`ifdef ADAPTER_CHECK_EN
   output logic [7:0]          spi_err_cnt,
`endif
   // SPI pins
   output logic                spi_sclk,
   output logic                spi_mosi,
   input  logic                spi_miso,
   output logic                spi_cs,
   // Button
   input  logic                btn_start,
   input  logic [PULSE_W-1:0]  btn_len,
   output logic                btn_out,
   // Sonar echo responders
   input  logic [PULSE_W-1:0]  echo_len,
   input  logic [NUM_ECHO-1:0] trig,
   output logic [NUM_ECHO-1:0] echo
);

   // ------------------------------------------------------------------------
   // SPI master
   // ------------------------------------------------------------------------
   localparam int DIV_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(DIV_MAX + 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

   typedef enum logic [2:0] {
      SPI_IDLE  = 3'd0,
      SPI_SETUP = 3'd1,
      SPI_SHIFT = 3'd2,
      SPI_HOLD  = 3'd3,
      SPI_GAP   = 3'd4
   } spi_state_t;

   spi_state_t       spi_state_q, spi_state_d;
   logic [CNT_W-1:0] spi_cnt_q, spi_cnt_d;
   logic [5:0]       bit_cnt_q, bit_cnt_d;   // SCLK rising edges issued so far
   logic [31:0]      tx_sh_q, tx_sh_d;
   logic [31:0]      rx_sh_q, rx_sh_d;
   logic [31:0]      rx_q, rx_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             cs_q, cs_d;
   logic             done_q, done_d;

`ifdef ADAPTER_CHECK_EN
   logic [31:0]      exp_q, exp_d;
   logic             exp_valid_q, exp_valid_d;
   logic             err_q, err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
`endif

   // SPI frame sequencing: next state, pin levels and shift registers
   always_comb begin
      spi_state_d = spi_state_q;
      spi_cnt_d   = spi_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      tx_sh_d     = tx_sh_q;
      rx_sh_d     = rx_sh_q;
      rx_d        = rx_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      cs_d        = cs_q;
      done_d      = 1'b0;
`ifdef ADAPTER_CHECK_EN
      exp_d       = exp_q;
      exp_valid_d = exp_valid_q;
      err_d       = err_q;
      err_cnt_d   = err_cnt_q;
`endif
      case (spi_state_q)
         SPI_IDLE: begin
            if (spi_start) begin
               tx_sh_d     = spi_tx;
               mosi_d      = spi_tx[31];
               cs_d        = 1'b0;
               spi_cnt_d   = '0;
               spi_state_d = SPI_SETUP;
`ifdef ADAPTER_CHECK_EN
               exp_d       = spi_exp;
               exp_valid_d = spi_exp_valid;
`endif
            end
         end
         SPI_SETUP: begin
            if (spi_cnt_q == DIV_LAST) begin
               // first rising edge: slave has had bit 31 on miso since CS fell
               spi_cnt_d   = '0;
               sclk_d      = 1'b1;
               rx_sh_d     = {rx_sh_q[30:0], spi_miso};
               bit_cnt_d   = 6'd1;
               spi_state_d = SPI_SHIFT;
            end else begin
               spi_cnt_d = spi_cnt_q + 1'b1;
            end
         end
         SPI_SHIFT: begin
            if (spi_cnt_q == DIV_LAST) begin
               spi_cnt_d = '0;
               if (sclk_q) begin
                  // falling edge: present the next bit unless all 32 are out
                  sclk_d = 1'b0;
                  if (bit_cnt_q != 6'd32) begin
                     tx_sh_d = {tx_sh_q[30:0], 1'b0};
                     mosi_d  = tx_sh_q[30];
                  end
               end else if (bit_cnt_q == 6'd32) begin
                  spi_state_d = SPI_HOLD;
               end else begin
                  sclk_d    = 1'b1;
                  rx_sh_d   = {rx_sh_q[30:0], spi_miso};
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end else begin
               spi_cnt_d = spi_cnt_q + 1'b1;
            end
         end
         SPI_HOLD: begin
            if (spi_cnt_q == DIV_LAST) begin
               spi_cnt_d   = '0;
               cs_d        = 1'b1;
               mosi_d      = 1'b0;
               rx_d        = rx_sh_q;
               done_d      = 1'b1;
               spi_state_d = SPI_GAP;
`ifdef ADAPTER_CHECK_EN
               if (exp_valid_q && (rx_sh_q != exp_q)) begin
                  err_d = 1'b1;
                  if (err_cnt_q != 8'hFF) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
               end
`endif
            end else begin
               spi_cnt_d = spi_cnt_q + 1'b1;
            end
         end
         SPI_GAP: begin
            if (spi_cnt_q == GAP_LAST) begin
               spi_cnt_d   = '0;
               spi_state_d = SPI_IDLE;
            end else begin
               spi_cnt_d = spi_cnt_q + 1'b1;
            end
         end
         default: begin
            spi_state_d = SPI_IDLE;
         end
      endcase
   end

   // SPI state register; reset abandons any frame with CS high at once
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spi_state_q <= SPI_IDLE;
         spi_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         rx_q        <= '0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         cs_q        <= 1'b1;
         done_q      <= 1'b0;
`ifdef ADAPTER_CHECK_EN
         exp_q       <= '0;
         exp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
`endif
      end else begin
         spi_state_q <= spi_state_d;
         spi_cnt_q   <= spi_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         rx_q        <= rx_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         cs_q        <= cs_d;
         done_q      <= done_d;
`ifdef ADAPTER_CHECK_EN
         exp_q       <= exp_d;
         exp_valid_q <= exp_valid_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
`endif
      end
   end

   assign spi_busy = (spi_state_q != SPI_IDLE);
   assign spi_done = done_q;
   assign spi_rx   = rx_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_cs   = cs_q;

`ifdef ADAPTER_CHECK_EN
   assign spi_err     = err_q;
   assign spi_err_cnt = err_cnt_q;
`else
   // expected-reply inputs have no function without checking
   logic unused_exp;
   assign unused_exp = ^{spi_exp, spi_exp_valid};
   assign spi_err    = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Button pulse generator
   // ------------------------------------------------------------------------
   logic [PULSE_W-1:0] btn_cnt_q, btn_cnt_d;
   logic               btn_q, btn_d;

   // A start with non-zero length (re)loads the remaining-cycles counter;
   // a zero-length start is ignored and leaves a running pulse untouched
   always_comb begin
      btn_cnt_d = btn_cnt_q;
      btn_d     = btn_q;
      if (btn_start && (btn_len != '0)) begin
         btn_cnt_d = btn_len;
         btn_d     = 1'b1;
      end else if (btn_cnt_q != '0) begin
         btn_cnt_d = btn_cnt_q - 1'b1;
         btn_d     = (btn_cnt_q != PULSE_W'(1));
      end
   end

   // Button register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_cnt_q <= '0;
         btn_q     <= 1'b0;
      end else begin
         btn_cnt_q <= btn_cnt_d;
         btn_q     <= btn_d;
      end
   end

   assign btn_out = btn_q;

   // ------------------------------------------------------------------------
   // Sonar echo responders
   // ------------------------------------------------------------------------
   localparam logic [PULSE_W-1:0] DLY_LAST = PULSE_W'(ECHO_DELAY - 1);

   typedef enum logic [1:0] {
      ECHO_IDLE = 2'd0,
      ECHO_WAIT = 2'd1,
      ECHO_HIGH = 2'd2
   } echo_state_t;

   for (genvar i = 0; i < NUM_ECHO; i++) begin : g_echo
      echo_state_t        st_q, st_d;
      logic [PULSE_W-1:0] cnt_q, cnt_d;
      logic [PULSE_W-1:0] len_q, len_d;
      logic               trig_prev_q, trig_prev_d;
      logic               out_q, out_d;
      logic               fall_w;

      assign fall_w = trig_prev_q & ~trig[i];

      // Trigger fall -> ECHO_DELAY cycles -> echo high for the latched length
      always_comb begin
         st_d        = st_q;
         cnt_d       = cnt_q;
         len_d       = len_q;
         out_d       = out_q;
         trig_prev_d = trig[i];
         case (st_q)
            ECHO_IDLE: begin
               if (fall_w && (echo_len != '0)) begin
                  len_d = echo_len;
                  cnt_d = '0;
                  st_d  = ECHO_WAIT;
               end
            end
            ECHO_WAIT: begin
               if (cnt_q == DLY_LAST) begin
                  cnt_d = len_q;
                  out_d = 1'b1;
                  st_d  = ECHO_HIGH;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ECHO_HIGH: begin
               if (cnt_q == PULSE_W'(1)) begin
                  cnt_d = '0;
                  out_d = 1'b0;
                  st_d  = ECHO_IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               st_d  = ECHO_IDLE;
               out_d = 1'b0;
            end
         endcase
      end

      // Per-channel echo register
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            st_q        <= ECHO_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            out_q       <= 1'b0;
            trig_prev_q <= 1'b0;
         end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_q       <= out_d;
            trig_prev_q <= trig_prev_d;
         end
      end

      assign echo[i] = out_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_host_stim_adapter.sv
// ============================================================================
// Module      : tb_host_stim_adapter
// Description : Directed self-checking bench for host_stim_adapter (SPI frame
//               timing and data, reply checking, button pulses, echoes,
//               mid-activity reset). Honours ADAPTER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_host_stim_adapter;

   localparam int CLK_DIV    = 2;
   localparam int CS_GAP     = 4;
   localparam int NUM_ECHO   = 6;
   localparam int ECHO_DELAY = 50;
   localparam int PULSE_W    = 24;
   localparam int CS_LOW     = 32 * 2 * CLK_DIV + 2 * CLK_DIV;  // SETUP+SHIFT+HOLD

`ifdef ADAPTER_CHECK_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                spi_start = 1'b0;
   logic [31:0]         spi_tx = '0;
   logic [31:0]         spi_exp = '0;
   logic                spi_exp_valid = 1'b0;
   logic                spi_busy, spi_done, spi_err;
   logic [31:0]         spi_rx;
   logic                spi_sclk, spi_mosi, spi_cs;
   logic                spi_miso = 1'b0;
   logic                btn_start = 1'b0;
   logic [PULSE_W-1:0]  btn_len = '0;
   logic                btn_out;
   logic [PULSE_W-1:0]  echo_len = '0;
   logic [NUM_ECHO-1:0] trig = '0;
   logic [NUM_ECHO-1:0] echo;
`ifdef ADAPTER_CHECK_EN
   logic [7:0]          spi_err_cnt;
`endif

   host_stim_adapter #(
      .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .NUM_ECHO(NUM_ECHO),
      .ECHO_DELAY(ECHO_DELAY), .PULSE_W(PULSE_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_start(spi_start), .spi_tx(spi_tx), .spi_exp(spi_exp),
      .spi_exp_valid(spi_exp_valid), .spi_busy(spi_busy), .spi_done(spi_done),
      .spi_rx(spi_rx), .spi_err(spi_err),
`ifdef ADAPTER_CHECK_EN
      .spi_err_cnt(spi_err_cnt),
`endif
      .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .spi_cs(spi_cs), .btn_start(btn_start), .btn_len(btn_len),
      .btn_out(btn_out), .echo_len(echo_len), .trig(trig), .echo(echo)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
      end
   endtask

   // Mode-0 SPI slave: loads reply on CS fall, shifts on SCLK fall,
   // captures MOSI and counts edges on SCLK rise
   logic [31:0] slv_reply = '0;
   logic [31:0] slv_sh    = '0;
   logic [31:0] slv_rx    = '0;
   int          rise_cnt  = 0;
   logic        prev_cs   = 1'b1;
   logic        prev_sclk = 1'b0;
   always @(spi_cs or spi_sclk) begin
      if (prev_cs && !spi_cs) begin
         slv_sh   = slv_reply;
         spi_miso = slv_sh[31];
      end else if (!spi_cs && prev_sclk && !spi_sclk) begin
         slv_sh   = {slv_sh[30:0], 1'b0};
         spi_miso = slv_sh[31];
      end
      if (!spi_cs && !prev_sclk && spi_sclk) begin
         slv_rx = {slv_rx[30:0], spi_mosi};
         rise_cnt++;
      end
      prev_cs   = spi_cs;
      prev_sclk = spi_sclk;
   end

   // Cycle counters for CS-low time and spi_done pulses
   int cs_low   = 0;
   int done_cnt = 0;
   always @(posedge clk) begin
      if (!spi_cs)  cs_low++;
      if (spi_done) done_cnt++;
   end

   // One complete frame; optionally pokes a start mid-frame that must be dropped
   task automatic spi_frame(input logic [31:0] tx, input logic [31:0] reply,
                            input logic [31:0] exp, input logic expv, input logic poke);
      int   r0, c0, d0, gap;
      logic seen;
      slv_reply     = reply;
      r0            = rise_cnt;
      c0            = cs_low;
      d0            = done_cnt;
      spi_tx        = tx;
      spi_exp       = exp;
      spi_exp_valid = expv;
      spi_start     = 1'b1;
      @(negedge clk);
      spi_start = 1'b0;
      chk("spi_busy_rise", spi_busy, 1);
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (poke && i == 20) begin
            spi_tx    = 32'hFFFF_FFFF;
            spi_start = 1'b1;
         end else begin
            spi_start = 1'b0;
         end
         @(negedge clk);
         if (spi_done) begin
            seen = 1'b1;
            break;
         end
      end
      spi_start = 1'b0;
      chk("spi_done_seen", seen, 1);
      chk("spi_rx", spi_rx, reply);
      gap = 0;
      for (int i = 0; i < 100 && spi_busy; i++) begin
         @(negedge clk);
         gap++;
      end
      chk("spi_gap_len", gap, CS_GAP);
      repeat (10) @(negedge clk);
      chk("spi_mosi_bits", slv_rx, tx);
      chk("spi_sclk_rises", rise_cnt - r0, 32);
      chk("spi_cs_low_cycles", cs_low - c0, CS_LOW);
      chk("spi_done_pulses", done_cnt - d0, 1);
   endtask

   initial begin
      int cnt, first, last, hi, all, mis, d0;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      chk("rst_cs", spi_cs, 1);
      chk("rst_sclk", spi_sclk, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_busy", spi_busy, 0);
      chk("rst_done", spi_done, 0);
      chk("rst_rx", spi_rx, 0);
      chk("rst_err", spi_err, 0);
      chk("rst_btn", btn_out, 0);
      chk("rst_echo", echo, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---------------- SPI basic frame, with a dropped mid-frame start ----
      spi_frame(32'hE000_0001, 32'h0100_0000, 32'h0, 1'b0, 1'b1);
      chk("err_no_check", spi_err, 0);

      // ---------------- reply checking ----------------
      spi_frame(32'h3000_0000, 32'h0B00_0000, 32'h0B00_0000, 1'b1, 1'b0);
      chk("err_match", spi_err, 0);
      spi_frame(32'h3000_0000, 32'h0B00_0001, 32'h0B00_0000, 1'b1, 1'b0);
      chk("err_mismatch", spi_err, CHK_EN);
      spi_frame(32'h3000_0000, 32'h0B00_0000, 32'h0B00_0000, 1'b1, 1'b0);
      chk("err_sticky", spi_err, CHK_EN);
`ifdef ADAPTER_CHECK_EN
      chk("err_cnt", spi_err_cnt, 1);
`endif

      // ---------------- button: 1500-cycle pulse ----------------
      btn_len   = 24'd1500;
      btn_start = 1'b1;
      cnt = 0; first = -1; last = -1;
      for (int i = 1; i <= 2000; i++) begin
         @(negedge clk);
         if (i == 1) btn_start = 1'b0;
         if (btn_out) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      chk("btn_first", first, 1);
      chk("btn_width", cnt, 1500);

      // ---------------- button: retrigger at 1000 with length 100 -------
      btn_start = 1'b1;
      cnt = 0; last = -1;
      for (int i = 1; i <= 2000; i++) begin
         @(negedge clk);
         if (i == 1 || i == 1001) btn_start = 1'b0;
         if (btn_out) begin
            cnt++;
            last = i;
         end
         if (i == 1000) begin
            btn_len   = 24'd100;
            btn_start = 1'b1;
         end
      end
      chk("btn_retrig_last", last, 1100);
      chk("btn_retrig_width", cnt, 1100);

      // ---------------- button: zero length ----------------
      btn_len   = '0;
      btn_start = 1'b1;
      cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         btn_start = 1'b0;
         if (btn_out) cnt++;
      end
      chk("btn_zero_len", cnt, 0);

      // ---------------- echo: single channel, retrigger ignored --------
      // trig drops half a cycle before the detecting edge, so the rise is
      // first visible ECHO_DELAY+1 falling clk edges after trig drops
      echo_len = 24'd500;
      trig     = 6'b000001;
      repeat (10) @(negedge clk);
      trig = '0;
      hi = 0; first = -1; mis = 0;
      for (int k = 1; k <= 800; k++) begin
         if (k == 100) trig[0] = 1'b1;
         if (k == 110) trig[0] = 1'b0;
         @(negedge clk);
         if (echo[0]) begin
            hi++;
            if (first < 0) first = k;
         end
         if (echo[5:1] != '0) mis++;
      end
      chk("echo0_delay", first, ECHO_DELAY + 1);
      chk("echo0_width", hi, 500);
      chk("echo0_others_quiet", mis, 0);

      // ---------------- echo: all channels aligned ----------------
      trig = 6'b111111;
      repeat (10) @(negedge clk);
      trig = '0;
      all = 0; first = -1; mis = 0;
      for (int k = 1; k <= 700; k++) begin
         @(negedge clk);
         if (echo == 6'b111111) begin
            all++;
            if (first < 0) first = k;
         end else if (echo != '0) begin
            mis++;
         end
      end
      chk("echo_all_delay", first, ECHO_DELAY + 1);
      chk("echo_all_width", all, 500);
      chk("echo_all_aligned", mis, 0);

      // ---------------- echo_len = 0 ----------------
      echo_len = '0;
      trig     = 6'b000010;
      repeat (5) @(negedge clk);
      trig = '0;
      hi = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (echo != '0) hi++;
      end
      chk("echo_zero_len", hi, 0);

      // ---------------- reset mid-frame and mid-echo ----------------
      echo_len      = 24'd500;
      trig          = 6'b000100;
      slv_reply     = 32'h1234_5678;
      spi_tx        = 32'hA5A5_5A5A;
      spi_exp_valid = 1'b0;
      spi_start     = 1'b1;
      @(negedge clk);
      spi_start = 1'b0;
      repeat (4) @(negedge clk);
      trig = '0;
      repeat (70) @(negedge clk);
      chk("pre_rst_echo2", echo[2], 1);
      chk("pre_rst_cs_low", spi_cs, 0);
      d0    = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_cs", spi_cs, 1);
      chk("mid_rst_sclk", spi_sclk, 0);
      chk("mid_rst_echo", echo, 0);
      chk("mid_rst_busy", spi_busy, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_rst_no_done", done_cnt - d0, 0);
      chk("mid_rst_echo_stays", echo, 0);
      chk("mid_rst_err_clear", spi_err, 0);

      // ---------------- frame after reset ----------------
      spi_frame(32'h5C3A_96F0, 32'h8765_4321, 32'h8765_4321, 1'b1, 1'b0);
      chk("post_rst_err", spi_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
